ktr_bin_scheduler: RTL and testbench

- Arbitrates one shared KTR binarization engine among NUM_REQ syntax-element requesters (e.g. coeff_abs_level_remaining, cu_qp_delta_abs, suffix paths).
- Latches the winning request's value N, rice parameter K and cMax, and drives the engine's start/operand ports.
- Waits for the engine's done, then returns bin string, length and requester ID on a valid/ready response channel.
- Sits between the per-element request front ends and the CABAC bin packer.

---
 rtl/ktr_sched_pkg.sv | 38 +++
 rtl/ktr_bin_scheduler_rr_arbiter.sv | 39 +++
 rtl/ktr_bin_scheduler.sv | 123 ++++++++++++
 tb/tb_ktr_bin_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ktr_sched_pkg.sv
// Shared types, default widths and the round-robin pick helper for the KTR bin scheduler.
package ktr_sched_pkg;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_e;

  localparam int unsigned DefNumReq     = 4;
  localparam int unsigned DefBinWidth   = 16;
  localparam int unsigned DefValueWidth = 8;
  localparam int unsigned DefTimeout    = 64;

  // Upper bound on requesters the pick helper can scan.
  localparam int unsigned MaxReq = 32;

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } pick_t;

  // First valid requester at or after ptr, wrapping modulo num.
  function automatic pick_t rr_pick(input logic [MaxReq-1:0] valid, input int unsigned ptr,
                                    input int unsigned num);
    pick_t       p;
    int unsigned j;
    p = '0;
    for (int unsigned i = 0; i < MaxReq; i++) begin
      if (i < num && !p.found) begin
        j = ptr + i;
        if (j >= num) j = j - num;
        if (valid[j]) begin
          p.found = 1'b1;
          p.idx   = j[4:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/ktr_bin_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner on accept.
module rr_arbiter
  import ktr_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DefNumReq,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  logic [ID_W-1:0]   ptr_q;
  logic [MaxReq-1:0] valid_ext;
  pick_t             pick;

  always_comb begin
    valid_ext              = '0;
    valid_ext[NUM_REQ-1:0] = valid;
    pick                   = rr_pick(valid_ext, 32'(ptr_q), NUM_REQ);
    found                  = pick.found;
    idx                    = ID_W'(pick.idx);
    grant                  = '0;
    if (pick.found) grant[idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (32'(idx) == NUM_REQ - 1) ? '0 : idx + ID_W'(1);
    end
  end

endmodule

// File: rtl/ktr_bin_scheduler.sv
// Shares one KTR binarization engine among NUM_REQ requesters; returns bins on a valid/ready
// response channel with a timeout error if the engine never signals done.
module ktr_bin_scheduler
  import ktr_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ     = DefNumReq,
  parameter int unsigned BIN_WIDTH   = DefBinWidth,
  parameter int unsigned VALUE_WIDTH = DefValueWidth,
  parameter int unsigned TIMEOUT     = DefTimeout,
  localparam int unsigned ID_W       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0] req_n_i,
  input  logic [NUM_REQ*BIN_WIDTH-1:0]   req_k_i,
  input  logic [NUM_REQ*BIN_WIDTH-1:0]   req_cmax_i,
  output logic                           eng_start_o,
  output logic [VALUE_WIDTH-1:0]         eng_n_o,
  output logic [BIN_WIDTH-1:0]           eng_k_o,
  output logic [BIN_WIDTH-1:0]           eng_cmax_o,
  input  logic                           eng_done_i,
  input  logic [BIN_WIDTH-1:0]           eng_bin_i,
  input  logic [BIN_WIDTH-1:0]           eng_len_i,
  output logic                           resp_valid_o,
  input  logic                           resp_ready_i,
  output logic [ID_W-1:0]                resp_id_o,
  output logic [BIN_WIDTH-1:0]           resp_bin_o,
  output logic [BIN_WIDTH-1:0]           resp_len_o,
  output logic                           resp_err_o,
  output logic                           busy_o
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e             state_q;
  logic [ID_W-1:0]    id_q;
  logic [CntW-1:0]    cnt_q;
  logic [NUM_REQ-1:0] grant;
  logic               found;
  logic               accept;
  logic [ID_W-1:0]    win;

  assign accept      = (state_q == IDLE) && found && !rst;
  assign req_ready_o = accept ? grant : '0;
  assign busy_o      = (state_q != IDLE);

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .valid (req_valid_i),
    .accept(accept),
    .grant (grant),
    .found (found),
    .idx   (win)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      id_q         <= '0;
      cnt_q        <= '0;
      eng_start_o  <= 1'b0;
      eng_n_o      <= '0;
      eng_k_o      <= '0;
      eng_cmax_o   <= '0;
      resp_valid_o <= 1'b0;
      resp_id_o    <= '0;
      resp_bin_o   <= '0;
      resp_len_o   <= '0;
      resp_err_o   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            eng_n_o     <= req_n_i[32'(win)*VALUE_WIDTH +: VALUE_WIDTH];
            eng_k_o     <= req_k_i[32'(win)*BIN_WIDTH +: BIN_WIDTH];
            eng_cmax_o  <= req_cmax_i[32'(win)*BIN_WIDTH +: BIN_WIDTH];
            id_q        <= win;
            eng_start_o <= 1'b1;
            state_q     <= START;
          end
        end
        START: begin
          eng_start_o <= 1'b0;
          cnt_q       <= '0;
          state_q     <= WAIT;
        end
        WAIT: begin
          // Done takes priority over a timeout landing in the same cycle.
          if (eng_done_i) begin
            resp_bin_o   <= eng_bin_i;
            resp_len_o   <= eng_len_i;
            resp_err_o   <= 1'b0;
            resp_id_o    <= id_q;
            resp_valid_o <= 1'b1;
            state_q      <= RESP;
          end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
            resp_bin_o   <= '0;
            resp_len_o   <= '0;
            resp_err_o   <= 1'b1;
            resp_id_o    <= id_q;
            resp_valid_o <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            resp_valid_o <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ktr_bin_scheduler.sv
// Bench for ktr_bin_scheduler: vector table, directed corner sequences and a randomized run
// checked against a request-level arbitration/response model.
module tb_ktr_bin_scheduler;
  localparam int NR = 4;
  localparam int BW = 16;
  localparam int VW = 8;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NR-1:0]   req_valid_i, req_ready_o;
  logic [NR*VW-1:0] req_n_i;
  logic [NR*BW-1:0] req_k_i, req_cmax_i;
  logic            eng_start_o, eng_done_i;
  logic [VW-1:0]   eng_n_o;
  logic [BW-1:0]   eng_k_o, eng_cmax_o, eng_bin_i, eng_len_i;
  logic            resp_valid_o, resp_ready_i, resp_err_o, busy_o;
  logic [1:0]      resp_id_o;
  logic [BW-1:0]   resp_bin_o, resp_len_o;

  ktr_bin_scheduler #(
    .NUM_REQ(NR), .BIN_WIDTH(BW), .VALUE_WIDTH(VW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_n_i(req_n_i), .req_k_i(req_k_i), .req_cmax_i(req_cmax_i),
    .eng_start_o(eng_start_o), .eng_n_o(eng_n_o), .eng_k_o(eng_k_o), .eng_cmax_o(eng_cmax_o),
    .eng_done_i(eng_done_i), .eng_bin_i(eng_bin_i), .eng_len_i(eng_len_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_id_o(resp_id_o),
    .resp_bin_o(resp_bin_o), .resp_len_o(resp_len_o), .resp_err_o(resp_err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Engine model: done is raised cfg_lat cycles after the start cycle (0 = never).
  int            cfg_lat = 0;
  logic [BW-1:0] cfg_bin = '0;
  logic [BW-1:0] cfg_len = '0;
  int            cd = 0;
  int            starts = 0;
  logic [VW-1:0] cap_n;
  logic [BW-1:0] cap_k, cap_c;

  initial begin
    eng_done_i = 1'b0;
    eng_bin_i  = '0;
    eng_len_i  = '0;
    forever begin
      @(posedge clk);
      #2;
      eng_done_i = 1'b0;
      if (!busy_o) begin
        cd = 0;
      end else if (eng_start_o) begin
        starts++;
        cap_n = eng_n_o;
        cap_k = eng_k_o;
        cap_c = eng_cmax_o;
        cd    = cfg_lat;
      end else if (cd > 0) begin
        cd--;
        eng_done_i = (cd == 0);
      end
      eng_bin_i = cfg_bin;
      eng_len_i = cfg_len;
    end
  end

  int gq[$];
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < NR; i++) if (req_ready_o[i]) gq.push_back(i);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  typedef struct {
    int            id;
    logic [VW-1:0] n;
    logic [BW-1:0] k, cmax;
    int            lat;
    logic [BW-1:0] eb, el;
    logic [BW-1:0] xb, xl;
    logic          xe;
    int            xlat;
  } tvec_t;

  tvec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [VW-1:0] n, input logic [BW-1:0] k,
                         input logic [BW-1:0] c);
    req_n_i[i*VW +: VW]    = n;
    req_k_i[i*BW +: BW]    = k;
    req_cmax_i[i*BW +: BW] = c;
  endtask

  task automatic do_reset();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_zero(input string name);
    check(name, 64'({req_ready_o, eng_start_o, resp_valid_o, resp_err_o, busy_o, resp_id_o}),
          64'(0));
    check({name, "_ops"}, 64'({eng_n_o, eng_k_o, eng_cmax_o}), 64'(0));
    check({name, "_res"}, 64'({resp_bin_o, resp_len_o}), 64'(0));
  endtask

  // Returns cycles from the grant cycle to the first resp_valid cycle, -1 if none.
  task automatic wait_resp(output int t);
    t = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid_o) begin
        t = c;
        break;
      end
    end
  endtask

  task automatic drain(input string name);
    logic ok;
    ok = 1'b0;
    resp_ready_i = 1'b1;
    for (int c = 0; c < 60; c++) begin
      tick();
      @(negedge clk);
      if (!busy_o && !resp_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    check(name, 64'(ok), 64'(1));
  endtask

  task automatic run_txn(input tvec_t v);
    int t;
    int s0;
    cfg_lat = v.lat;
    cfg_bin = v.eb;
    cfg_len = v.el;
    s0      = starts;
    tick();
    req_valid_i       = '0;
    req_valid_i[v.id] = 1'b1;
    set_req(v.id, v.n, v.k, v.cmax);
    resp_ready_i = 1'b1;
    @(negedge clk);
    check("vec_grant", 64'(req_ready_o), 64'(4'b0001 << v.id));
    tick();
    req_valid_i = '0;
    wait_resp(t);
    check("vec_latency", 64'(t), 64'(v.xlat));
    check("vec_id", 64'(resp_id_o), 64'(v.id));
    check("vec_bin", 64'(resp_bin_o), 64'(v.xb));
    check("vec_len", 64'(resp_len_o), 64'(v.xl));
    check("vec_err", 64'(resp_err_o), 64'(v.xe));
    check("vec_starts", 64'(starts - s0), 64'(1));
    check("vec_eng_ops", 64'({cap_n, cap_k, cap_c}), 64'({v.n, v.k, v.cmax}));
    tick();
    @(negedge clk);
    check("vec_idle_after", 64'({busy_o, resp_valid_o}), 64'(0));
  endtask

  logic [NR-1:0] pend;
  int            mptr, drop_idx, w, lat, xid, ngr, nresp, t, s0;
  bit            midle, reopen, allow_new;
  logic [BW-1:0] xb, xl;
  logic          xe;
  logic [NR-1:0] exp_g;

  initial begin
    rst          = 1'b1;
    req_valid_i  = '0;
    req_n_i      = '0;
    req_k_i      = '0;
    req_cmax_i   = '0;
    resp_ready_i = 1'b0;

    // Latency = 2 + done delay; a timeout behaves like done on the TIMEOUT-th wait cycle.
    vecs[0] = '{2, 8'd5, 16'd1, 16'd8, 3, 16'h000D, 16'd4, 16'h000D, 16'd4, 1'b0, 5};
    vecs[1] = '{0, 8'hFF, 16'hFFFF, 16'h1234, 1, 16'hA5A5, 16'd16, 16'hA5A5, 16'd16, 1'b0, 3};
    vecs[2] = '{3, 8'h3C, 16'd2, 16'h0020, 0, 16'hBEEF, 16'd9, 16'h0000, 16'h0000, 1'b1, 10};
    vecs[3] = '{1, 8'd7, 16'd2, 16'd3, 8, 16'h001F, 16'd5, 16'h001F, 16'd5, 1'b0, 10};
    vecs[4] = '{2, 8'h80, 16'd4, 16'h0040, 7, 16'h0F0F, 16'd12, 16'h0F0F, 16'd12, 1'b0, 9};

    tick();
    tick();
    @(negedge clk);
    check_zero("reset");
    tick();
    rst = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i]);

    // Fairness: everyone requesting continuously from a fresh pointer.
    do_reset();
    gq.delete();
    cfg_lat = 1;
    cfg_bin = 16'h0003;
    cfg_len = 16'd2;
    for (int i = 0; i < NR; i++) set_req(i, VW'(i + 1), BW'(i), BW'(10 + i));
    req_valid_i  = '1;
    resp_ready_i = 1'b1;
    for (int c = 0; c < 100 && gq.size() < 6; c++) tick();
    req_valid_i = '0;
    drain("fair_drain");
    check("fair_count", 64'(gq.size()), 64'(6));
    for (int i = 0; i < 6 && i < gq.size(); i++) check("fair_order", 64'(gq[i]), 64'(i % NR));

    // Backpressure: pointer now sits at 2; requester 3 waits behind a stalled response.
    cfg_lat = 2;
    cfg_bin = 16'h1357;
    cfg_len = 16'd11;
    tick();
    req_valid_i = 4'b1100;
    @(negedge clk);
    check("bp_grant", 64'(req_ready_o), 64'(4'b0100));
    tick();
    req_valid_i  = 4'b1000;
    resp_ready_i = 1'b0;
    wait_resp(t);
    check("bp_latency", 64'(t), 64'(4));
    s0 = starts;
    for (int c = 0; c < 10; c++) begin
      tick();
      @(negedge clk);
      check("bp_hold", 64'({resp_valid_o, resp_id_o, resp_bin_o, resp_len_o, resp_err_o}),
            64'({1'b1, 2'd2, 16'h1357, 16'd11, 1'b0}));
      check("bp_no_grant", 64'({req_ready_o, eng_start_o}), 64'(0));
    end
    check("bp_no_start", 64'(starts - s0), 64'(0));
    tick();
    resp_ready_i = 1'b1;
    tick();
    @(negedge clk);
    check("bp_next_grant", 64'(req_ready_o), 64'(4'b1000));
    tick();
    req_valid_i = '0;
    drain("bp_drain");

    // Reset in the middle of WAIT: response dropped and pointer back to 0.
    cfg_lat = 0;
    tick();
    req_valid_i = 4'b0010;
    @(negedge clk);
    check("mr_grant", 64'(req_ready_o), 64'(4'b0010));
    tick();
    req_valid_i = '0;
    tick();
    tick();
    @(negedge clk);
    check("mr_busy", 64'(busy_o), 64'(1));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    cfg_lat = 2;
    tick();
    req_valid_i = 4'b0110;
    @(negedge clk);
    check("mr_ptr_zero", 64'(req_ready_o), 64'(4'b0010));
    tick();
    req_valid_i = '0;
    drain("mr_drain");

    // Randomized run against the request-level model.
    do_reset();
    pend     = '0;
    mptr     = 0;
    drop_idx = -1;
    midle    = 1'b1;
    reopen   = 1'b0;
    ngr      = 0;
    nresp    = 0;
    xid      = 0;
    xb       = '0;
    xl       = '0;
    xe       = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      allow_new = (cyc < 2950);
      tick();
      if (drop_idx >= 0) pend[drop_idx] = 1'b0;
      drop_idx = -1;
      if (reopen) midle = 1'b1;
      reopen = 1'b0;
      for (int i = 0; i < NR; i++) begin
        if (!allow_new) begin
          pend[i] = 1'b0;
        end else if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          set_req(i, VW'($urandom), BW'($urandom), BW'($urandom));
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      req_valid_i  = pend;
      resp_ready_i = allow_new ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      w = -1;
      if (midle) begin
        for (int k = 0; k < NR; k++) if (w < 0 && pend[(mptr + k) % NR]) w = (mptr + k) % NR;
      end
      exp_g = (w >= 0) ? (4'b0001 << w) : 4'b0000;
      check("rnd_grant", 64'(req_ready_o), 64'(exp_g));
      if (resp_valid_o && resp_ready_i) begin
        check("rnd_resp", 64'({resp_id_o, resp_bin_o, resp_len_o, resp_err_o}),
              64'({2'(xid), xb, xl, xe}));
        reopen = 1'b1;
        nresp++;
      end
      if (w >= 0) begin
        lat     = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
        cfg_lat = lat;
        cfg_bin = BW'($urandom);
        cfg_len = BW'($urandom);
        xid     = w;
        xb      = (lat == 0) ? '0 : cfg_bin;
        xl      = (lat == 0) ? '0 : cfg_len;
        xe      = (lat == 0);
        midle   = 1'b0;
        mptr    = (w + 1) % NR;
        drop_idx = w;
        ngr++;
      end
    end
    check("rnd_all_responded", 64'(nresp), 64'(ngr));
    check("rnd_enough_traffic", 64'(ngr > 100), 64'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
